// File: rtl/med_sched_multi.sv
// med_sched_multi
//   Multi-slot medication scheduler and event logger. A wrapping timebase
//   advances on each tick. Every dose slot holds an enable, a next-due time
//   and a repeat period. When the timebase reaches a slot's next-due time on
//   a tick, the slot fires: it raises its due flag and queues a DUE event, or
//   a MISSED event if the previous dose was never acknowledged. ACK commands
//   clear due flags and queue ACK events. Queued events drain one per cycle,
//   lowest slot first, into a show-ahead log FIFO.
//
// Ports
//   clk, rst      : single clock, synchronous active-high reset
//   tick          : one-cycle timebase advance strobe
//   cmd_valid     : command strobe (always accepted)
//   cmd_op        : 0 NOP, 1 SET_TIME, 2 SET_PERIOD, 3 ACK, 4 DISABLE,
//                   5 CLEAR_LOG, 6-7 NOP
//   cmd_slot      : target slot (out-of-range index ignores the command)
//   cmd_data      : time / period operand
//   log_pop       : consume the head log entry
//   due           : per-slot dose-due flags
//   alarm         : OR of due
//   now           : current timebase
//   log_valid     : log FIFO not empty
//   log_data      : head entry {type[1:0], slot, time}; 01 DUE, 10 ACK, 11 MISSED
//   log_count     : log FIFO occupancy
//   log_overflow  : sticky, an event was dropped because the FIFO was full
//
// Log handshake: log_data is valid whenever log_valid is 1. Asserting
// log_pop while log_valid is 1 consumes the head at the next clock edge;
// log_pop while log_valid is 0 has no effect.

module med_sched_multi #(
    parameter int NUM_SLOTS = 4,
    parameter int TIME_W    = 8,
    parameter int LOG_DEPTH = 16,
    localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int ENTRY_W  = 2 + SLOT_W + TIME_W,
    localparam int CNT_W    = $clog2(LOG_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd_op,
    input  logic [SLOT_W-1:0]    cmd_slot,
    input  logic [TIME_W-1:0]    cmd_data,
    input  logic                 log_pop,
    output logic [NUM_SLOTS-1:0] due,
    output logic                 alarm,
    output logic [TIME_W-1:0]    now,
    output logic                 log_valid,
    output logic [ENTRY_W-1:0]   log_data,
    output logic [CNT_W-1:0]     log_count,
    output logic                 log_overflow
);

    localparam int PTR_W = $clog2(LOG_DEPTH);

    localparam logic [2:0] OP_SET_TIME   = 3'd1;
    localparam logic [2:0] OP_SET_PERIOD = 3'd2;
    localparam logic [2:0] OP_ACK        = 3'd3;
    localparam logic [2:0] OP_DISABLE    = 3'd4;
    localparam logic [2:0] OP_CLEAR_LOG  = 3'd5;

    localparam logic [1:0] EV_DUE  = 2'b01;
    localparam logic [1:0] EV_ACK  = 2'b10;
    localparam logic [1:0] EV_MISS = 2'b11;

    // ---------------- slot state ----------------
    logic [TIME_W-1:0]    now_q;
    logic [NUM_SLOTS-1:0] en_q, due_q, pa_q, pm_q, pd_q;
    logic [NUM_SLOTS-1:0] en_d, due_d, pa_d, pm_d, pd_d;
    logic [TIME_W-1:0]    next_q   [NUM_SLOTS];
    logic [TIME_W-1:0]    period_q [NUM_SLOTS];
    logic [TIME_W-1:0]    next_d   [NUM_SLOTS];
    logic [TIME_W-1:0]    period_d [NUM_SLOTS];

    // ---------------- log FIFO state ----------------
    logic [ENTRY_W-1:0] mem [LOG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;

    logic               clear_log;
    logic               log_wr;
    logic [ENTRY_W-1:0] log_entry;
    logic               fifo_full, fifo_empty, do_pop, do_push;

    assign clear_log  = cmd_valid && (cmd_op == OP_CLEAR_LOG);
    assign fifo_full  = (count_q == CNT_W'(LOG_DEPTH));
    assign fifo_empty = (count_q == '0);

    always_comb begin
        en_d      = en_q;
        due_d     = due_q;
        pa_d      = pa_q;
        pm_d      = pm_q;
        pd_d      = pd_q;
        next_d    = next_q;
        period_d  = period_q;
        log_wr    = 1'b0;
        log_entry = '0;

        // Logger: pick the lowest slot with anything pending; within a slot
        // ACK beats MISSED beats DUE. Its pending bit clears here, before
        // any fire below, so a new event raised this cycle is never lost.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!log_wr && (pa_q[i] || pm_q[i] || pd_q[i])) begin
                log_wr = 1'b1;
                if (pa_q[i]) begin
                    log_entry = {EV_ACK, SLOT_W'(i), now_q};
                    pa_d[i]   = 1'b0;
                end else if (pm_q[i]) begin
                    log_entry = {EV_MISS, SLOT_W'(i), now_q};
                    pm_d[i]   = 1'b0;
                end else begin
                    log_entry = {EV_DUE, SLOT_W'(i), now_q};
                    pd_d[i]   = 1'b0;
                end
            end
        end

        if (clear_log) begin
            log_wr = 1'b0;
            pa_d   = '0;
            pm_d   = '0;
            pd_d   = '0;
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            // Command first, so fire evaluation sees post-command state.
            if (cmd_valid && (cmd_slot == SLOT_W'(i))) begin
                case (cmd_op)
                    OP_SET_TIME: begin
                        next_d[i] = cmd_data;
                        en_d[i]   = 1'b1;
                        due_d[i]  = 1'b0;
                    end
                    OP_SET_PERIOD: period_d[i] = cmd_data;
                    OP_ACK: begin
                        if (due_d[i]) begin
                            due_d[i] = 1'b0;
                            pa_d[i]  = 1'b1;
                        end
                    end
                    OP_DISABLE: begin
                        en_d[i]  = 1'b0;
                        due_d[i] = 1'b0;
                    end
                    default: ;
                endcase
            end

            if (tick && en_d[i] && (now_q == next_d[i])) begin
                next_d[i] = next_d[i] + period_d[i];
                if (period_d[i] == '0)
                    en_d[i] = 1'b0;     // one-shot
                if (due_d[i]) begin
                    pm_d[i] = 1'b1;
                end else begin
                    due_d[i] = 1'b1;
                    pd_d[i]  = 1'b1;
                end
            end
        end
    end

    // When full, a simultaneous pop frees the slot the write needs.
    assign do_pop  = log_pop && !fifo_empty && !clear_log;
    assign do_push = log_wr && (!fifo_full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            now_q      <= '0;
            en_q       <= '0;
            due_q      <= '0;
            pa_q       <= '0;
            pm_q       <= '0;
            pd_q       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                next_q[i]   <= '0;
                period_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (tick)
                now_q <= now_q + TIME_W'(1);
            en_q     <= en_d;
            due_q    <= due_d;
            pa_q     <= pa_d;
            pm_q     <= pm_d;
            pd_q     <= pd_d;
            next_q   <= next_d;
            period_q <= period_d;

            if (clear_log) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (do_push)
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (do_pop)
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (do_push && !do_pop)
                    count_q <= count_q + CNT_W'(1);
                else if (do_pop && !do_push)
                    count_q <= count_q - CNT_W'(1);
                if (log_wr && !do_push)
                    overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the output is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[wr_ptr_q] <= log_entry;
    end

    assign due          = due_q;
    assign alarm        = |due_q;
    assign now          = now_q;
    assign log_valid    = !fifo_empty;
    assign log_data     = fifo_empty ? '0 : mem[rd_ptr_q];
    assign log_count    = count_q;
    assign log_overflow = overflow_q;

endmodule

// File: tb/tb_med_sched_multi.sv
// tb_med_sched_multi
//   Directed bench for med_sched_multi with default parameters
//   (4 slots, 8-bit time, 16-entry log). Inputs are driven 1 time unit
//   after a rising edge and held for one cycle; outputs are checked at the
//   same point, after the edge that consumed the previous inputs.
//   Log entry = {type[1:0], slot[1:0], time[7:0]}.

module tb_med_sched_multi;

    localparam logic [2:0] NOP = 3'd0, SET_TIME = 3'd1, SET_PERIOD = 3'd2,
                           ACK = 3'd3, DISABLE = 3'd4, CLEAR_LOG = 3'd5;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        tick, cmd_valid, log_pop;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_slot;
    logic [7:0]  cmd_data;
    logic [3:0]  due;
    logic        alarm, log_valid, log_overflow;
    logic [7:0]  now;
    logic [11:0] log_data;
    logic [4:0]  log_count;

    med_sched_multi dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_slot     (cmd_slot),
        .cmd_data     (cmd_data),
        .log_pop      (log_pop),
        .due          (due),
        .alarm        (alarm),
        .now          (now),
        .log_valid    (log_valid),
        .log_data     (log_data),
        .log_count    (log_count),
        .log_overflow (log_overflow)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic t, input logic v, input logic [2:0] op,
                       input logic [1:0] sl, input logic [7:0] d, input logic p);
        tick      = t;
        cmd_valid = v;
        cmd_op    = op;
        cmd_slot  = sl;
        cmd_data  = d;
        log_pop   = p;
        @(posedge clk);
        #1;
        tick      = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        log_pop   = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, NOP, 2'd0, 8'd0, 1'b0);
    endtask

    task automatic tk();
        cyc(1'b1, 1'b0, NOP, 2'd0, 8'd0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tk();
    endtask

    task automatic cmd(input logic [2:0] op, input logic [1:0] sl, input logic [7:0] d);
        cyc(1'b0, 1'b1, op, sl, d, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, NOP, 2'd0, 8'd0, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_due"},   due, 4'h0);
        chk({tag, "_alarm"}, alarm, 1'b0);
        chk({tag, "_now"},   now, 8'h00);
        chk({tag, "_valid"}, log_valid, 1'b0);
        chk({tag, "_count"}, log_count, 5'd0);
        chk({tag, "_ovf"},   log_overflow, 1'b0);
        chk({tag, "_data"},  log_data, 12'h000);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; tick = 1'b0; cmd_valid = 1'b0; cmd_op = NOP;
        cmd_slot = 2'd0; cmd_data = 8'd0; log_pop = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_reset_outputs("rst");
        rst = 1'b0;
        idle();

        // Basic one-shot due on slot 0 at time 5
        cmd(SET_TIME, 2'd0, 8'd5);
        cmd(SET_PERIOD, 2'd0, 8'd0);
        ticks(5);
        chk("basic_now5", now, 8'd5);
        chk("basic_due_before", due, 4'h0);
        tk();
        chk("basic_due", due, 4'b0001);
        chk("basic_alarm", alarm, 1'b1);
        chk("basic_now6", now, 8'd6);
        chk("basic_no_log_yet", log_valid, 1'b0);
        idle();
        chk("basic_log_valid", log_valid, 1'b1);
        chk("basic_log_data", log_data, 12'h406);
        chk("basic_log_count", log_count, 5'd1);
        ticks(3);
        chk("oneshot_no_refire", log_count, 5'd1);
        chk("oneshot_due_held", due, 4'b0001);
        pop();
        chk("pop_count", log_count, 5'd0);
        chk("pop_valid", log_valid, 1'b0);

        // ACK on due slot, then ACK on non-due slot
        cmd(ACK, 2'd0, 8'd0);
        chk("ack_due_clr", due, 4'h0);
        chk("ack_alarm_clr", alarm, 1'b0);
        idle();
        chk("ack_log", log_data, 12'h809);
        chk("ack_count", log_count, 5'd1);
        cmd(ACK, 2'd0, 8'd0);
        idle();
        chk("ack2_ignored", log_count, 5'd1);
        pop();

        // Periodic slot 1: DUE then MISSED
        cmd(SET_TIME, 2'd1, 8'd12);
        cmd(SET_PERIOD, 2'd1, 8'd4);
        ticks(3);
        tk();
        chk("per_due", due, 4'b0010);
        chk("per_now", now, 8'd13);
        idle();
        chk("per_due_log", log_data, 12'h50D);
        ticks(3);
        tk();
        chk("per_miss_due", due, 4'b0010);
        idle();
        chk("per_count", log_count, 5'd2);
        chk("per_head", log_data, 12'h50D);
        pop();
        chk("per_miss_log", log_data, 12'hD11);
        chk("per_count1", log_count, 5'd1);
        pop();

        // Wrap of next_time: 0xFE + 4 -> 0x02
        cmd(SET_TIME, 2'd1, 8'hFE);
        chk("wrap_settime_clr", due, 4'h0);
        ticks(237);
        chk("wrap_now", now, 8'hFE);
        chk("wrap_quiet", log_count, 5'd0);
        tk();
        chk("wrap_due", due, 4'b0010);
        idle();
        chk("wrap_due_log", log_data, 12'h5FF);
        ticks(3);
        chk("wrap_no_early", log_count, 5'd1);
        chk("wrap_now2", now, 8'h02);
        tk();
        idle();
        chk("wrap_count", log_count, 5'd2);
        pop();
        chk("wrap_miss_log", log_data, 12'hD03);
        pop();
        cmd(DISABLE, 2'd1, 8'd0);
        chk("disable_due", due, 4'h0);
        chk("disable_nolog", log_count, 5'd0);

        // Simultaneous fire on slots 0, 2, 3 at time 6 (now is 3)
        cmd(SET_TIME, 2'd0, 8'd6);
        cmd(SET_TIME, 2'd2, 8'd6);
        cmd(SET_TIME, 2'd3, 8'd6);
        ticks(3);
        tk();
        chk("sim_due", due, 4'b1101);
        idle();
        chk("sim_c1", log_count, 5'd1);
        chk("sim_head0", log_data, 12'h407);
        idle();
        chk("sim_c2", log_count, 5'd2);
        idle();
        chk("sim_c3", log_count, 5'd3);
        pop();
        chk("sim_head2", log_data, 12'h607);
        pop();
        chk("sim_head3", log_data, 12'h707);
        pop();
        chk("sim_empty", log_count, 5'd0);

        // ACK and fire on the same slot in the same cycle (now is 7)
        cmd(SET_PERIOD, 2'd2, 8'd1);
        cmd(SET_TIME, 2'd2, 8'd7);
        chk("af_due_pre", due, 4'b1001);
        tk();
        chk("af_due1", due, 4'b1101);
        idle();
        chk("af_due_log", log_data, 12'h608);
        cyc(1'b1, 1'b1, ACK, 2'd2, 8'd0, 1'b0);
        chk("af_due_kept", due, 4'b1101);
        idle();
        idle();
        chk("af_count", log_count, 5'd3);
        pop();
        chk("af_ack_log", log_data, 12'hA09);
        pop();
        chk("af_due2_log", log_data, 12'h609);
        pop();
        chk("af_no_miss", log_count, 5'd0);
        cmd(DISABLE, 2'd2, 8'd0);
        cmd(CLEAR_LOG, 2'd0, 8'd0);
        chk("af_clear", log_count, 5'd0);

        // FIFO full: 17 events into 16 entries (now is 9)
        cmd(SET_PERIOD, 2'd0, 8'd1);
        cmd(SET_TIME, 2'd0, 8'd9);
        chk("full_due_pre", due, 4'b1000);
        ticks(17);
        chk("full_count", log_count, 5'd16);
        chk("full_no_ovf_yet", log_overflow, 1'b0);
        chk("full_head", log_data, 12'h40A);
        cmd(DISABLE, 2'd0, 8'd0);
        chk("full_count_held", log_count, 5'd16);
        chk("full_ovf", log_overflow, 1'b1);
        cmd(SET_TIME, 2'd0, 8'd26);
        tk();
        pop();
        chk("popwr_count", log_count, 5'd16);
        chk("popwr_head", log_data, 12'hC0B);
        chk("popwr_ovf_sticky", log_overflow, 1'b1);
        cmd(CLEAR_LOG, 2'd0, 8'd0);
        chk("clr_count", log_count, 5'd0);
        chk("clr_ovf", log_overflow, 1'b0);
        chk("clr_valid", log_valid, 1'b0);
        chk("clr_due_kept", due, 4'b1001);
        pop();
        chk("pop_empty", log_count, 5'd0);

        // Reset while entries are pending (now is 27)
        cmd(SET_TIME, 2'd2, 8'd27);
        cmd(SET_TIME, 2'd3, 8'd27);
        tk();
        chk("rd_due", due, 4'b1101);
        idle();
        chk("rd_count", log_count, 5'd1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk_reset_outputs("rst2");
        idle();
        idle();
        idle();
        chk("rst2_no_stale", log_count, 5'd0);
        chk("rst2_valid", log_valid, 1'b0);
        chk("rst2_due", due, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
